// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, ALUOp codes and issue-buffer state encoding.
// Also used by the ALU itself, so these values must stay in sync with it.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_RSVD   = 2'b11;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } issue_state_t;

endpackage

// File: rtl/alu_ctrl_enc.sv
// Combinational ALU control encoder: maps ALUOp/funct3/funct7b5 to a control code.
// Unsupported encodings fall back to ADD and raise illegal.
module alu_ctrl_enc
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_ctrl,
    output logic       illegal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        case (alu_op)
            ALUOP_MEM:    alu_ctrl = ALU_ADD;
            ALUOP_BRANCH: alu_ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct3)
                    F3_ADDSUB: alu_ctrl = funct7b5 ? ALU_SUB : ALU_ADD;
                    F3_AND:    alu_ctrl = ALU_AND;
                    F3_OR:     alu_ctrl = ALU_OR;
                    default:   illegal  = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: encodes decoded instructions and buffers them in a 2-entry FIFO
// whose head entry drives the outputs straight from registers.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 64
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_alu_op,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic            in_alu_src,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_in1,
    output logic [XLEN-1:0] out_in2,
    output logic [3:0]      out_alu_ctrl,
    output logic            out_illegal
);

    issue_state_t    state;
    logic [3:0]      enc_ctrl;
    logic            enc_illegal;
    logic [XLEN-1:0] new_in2;
    logic [XLEN-1:0] tail_in1;
    logic [XLEN-1:0] tail_in2;
    logic [3:0]      tail_ctrl;
    logic            tail_illegal;
    logic            push;
    logic            pop;
    logic            load_head;
    logic            load_tail;
    logic            shift_tail;

    alu_ctrl_enc u_enc (
        .alu_op   (in_alu_op),
        .funct3   (in_funct3),
        .funct7b5 (in_funct7b5),
        .alu_ctrl (enc_ctrl),
        .illegal  (enc_illegal)
    );

    assign new_in2 = in_alu_src ? in_imm : in_rs2;
    assign push    = in_valid && in_ready;
    assign pop     = out_valid && out_ready;

    // The head slot is the output register; a new entry goes straight to the head
    // whenever the head is free or being drained this cycle, otherwise to the tail.
    assign load_head  = !flush && push && ((state == ST_EMPTY) || (state == ST_ONE && pop));
    assign load_tail  = !flush && push && (state == ST_ONE) && !pop;
    assign shift_tail = !flush && pop && (state == ST_FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        state     <= ST_ONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        state    <= ST_FULL;
                        in_ready <= 1'b0;
                    end else if (!push && pop) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state    <= ST_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_in1      <= '0;
            out_in2      <= '0;
            out_alu_ctrl <= ALU_AND;
            out_illegal  <= 1'b0;
            tail_in1     <= '0;
            tail_in2     <= '0;
            tail_ctrl    <= ALU_AND;
            tail_illegal <= 1'b0;
        end else begin
            if (load_head) begin
                out_in1      <= in_rs1;
                out_in2      <= new_in2;
                out_alu_ctrl <= enc_ctrl;
                out_illegal  <= enc_illegal;
            end else if (shift_tail) begin
                out_in1      <= tail_in1;
                out_in2      <= tail_in2;
                out_alu_ctrl <= tail_ctrl;
                out_illegal  <= tail_illegal;
            end
            if (load_tail) begin
                tail_in1     <= in_rs1;
                tail_in2     <= new_in2;
                tail_ctrl    <= enc_ctrl;
                tail_illegal <= enc_illegal;
            end
        end
    end

endmodule
